// File: rtl/nic.sv
// Processor-to-router network interface with one-entry input (ICB) and output (OCB) buffers.
// Latency: a processor access at edge k updates d_out at that same edge; a router packet lands in ICB at its accept edge.
// Backpressure: net_ri drops while ICB is full; OCB writes are dropped while OCB is full; net_so waits for net_ro and a polarity match.
//
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   addr, d_in, d_out : processor register select (00 ICB, 01 ICB status, 10 OCB, 11 OCB status), write data, registered read data
//   nicEn, nicEnWr    : access strobe and write qualifier
//   net_si/ri/di      : router -> NIC packet offer, NIC ready, packet data
//   net_so/ro/do      : NIC -> router packet offer, router ready, packet data
//   net_polarity      : router's current even/odd phase, matched against OCB virtual-channel bit
module nic #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ICB  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ICS  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OCB  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OCS  = ADDR_WIDTH'(3);

  logic [DATA_WIDTH-1:0] icb_q, icb_d;
  logic [DATA_WIDTH-1:0] ocb_q, ocb_d;
  logic                  ics_q, ics_d;
  logic                  ocs_q, ocs_d;
  logic [DATA_WIDTH-1:0] d_out_q, d_out_d;

  logic rd_en;
  logic wr_en;

  assign rd_en = nicEn & ~nicEnWr;
  assign wr_en = nicEn & nicEnWr;

  // Handshake outputs come from registered state and polarity only, so there
  // is no combinational path from net_si or net_ro back to the router.
  assign net_ri = ~ics_q;
  // Bit 63 is the virtual-channel bit; a packet only goes out in its own phase.
  assign net_so = ocs_q & (ocb_q[DATA_WIDTH-1] == net_polarity);
  assign net_do = ocb_q;
  assign d_out  = d_out_q;

  always_comb begin
    icb_d   = icb_q;
    ics_d   = ics_q;
    ocb_d   = ocb_q;
    ocs_d   = ocs_q;
    d_out_d = d_out_q;

    // Router write: only possible while ICB is empty, so it can never collide
    // with the read-clear below (which only acts when ICB is full).
    if (net_si && !ics_q) begin
      icb_d = net_di;
      ics_d = 1'b1;
    end

    // Status reads use pre-edge flags regardless of same-cycle transfers.
    if (rd_en) begin
      case (addr)
        ADDR_ICB: begin
          d_out_d = icb_q;
          if (ics_q) ics_d = 1'b0;
        end
        ADDR_ICS: d_out_d = {{(DATA_WIDTH-1){1'b0}}, ics_q};
        ADDR_OCB: d_out_d = ocb_q;
        ADDR_OCS: d_out_d = {{(DATA_WIDTH-1){1'b0}}, ocs_q};
        default:  d_out_d = d_out_q;
      endcase
    end

    // OCB write and drain need opposite ocs_q values, so they are exclusive.
    if (wr_en && (addr == ADDR_OCB) && !ocs_q) begin
      ocb_d = d_in;
      ocs_d = 1'b1;
    end

    // Drain keeps OCB data; only the full flag drops.
    if (net_so && net_ro) begin
      ocs_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      icb_q   <= '0;
      ics_q   <= 1'b0;
      ocb_q   <= '0;
      ocs_q   <= 1'b0;
      d_out_q <= '0;
    end else begin
      icb_q   <= icb_d;
      ics_q   <= ics_d;
      ocb_q   <= ocb_d;
      ocs_q   <= ocs_d;
      d_out_q <= d_out_d;
    end
  end

endmodule

// File: doc/nic.md
# nic

Network interface controller between the processor pipeline and the local router port. The processor reaches it through stage-3 NIC accesses (`nicEn`, `nicEnWr`, 2-bit address, 64-bit write data, 64-bit read data `nic_dataOut`). Packets move to and from the router over a ready/valid link with a polarity gate. The block holds one single-entry input channel buffer (ICB) and one single-entry output channel buffer (OCB), each with a full/empty status flag.

## Interface
- `DATA_WIDTH`, 64, packet and processor data width
- `ADDR_WIDTH`, 2, processor-side register address width

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset, synchronous, active-low
- `addr`  in  2  register select: 00 = ICB, 01 = ICB status, 10 = OCB, 11 = OCB status
- `d_in`  in  64  processor write data
- `d_out`  out  64  processor read data, registered; drives the pipeline's `nic_dataOut`
- `nicEn`  in  1  access strobe, one cycle per access
- `nicEnWr`  in  1  with `nicEn`: 1 = write, 0 = read
- `net_si`  in  1  router offers a packet to the NIC
- `net_ri`  out  1  NIC can accept a packet (ICB empty)
- `net_di`  in  64  router packet data
- `net_so`  out  1  NIC offers a packet to the router
- `net_ro`  in  1  router can accept a packet
- `net_do`  out  64  packet to the router (equals OCB)
- `net_polarity`  in  1  router's current even/odd phase

## Operation
- State: ICB[63:0], `ics` (1 = full), OCB[63:0], `ocs` (1 = full), `d_out` register.
- `net_ri` = ~`ics`, combinational from state only.
- Router write:
  - Occurs on an edge where `net_si` && `net_ri`.
  - Effect: ICB <= `net_di`, `ics` <= 1.
- Processor read (`nicEn`=1, `nicEnWr`=0):
  - addr 00: `d_out` <= ICB. If `ics`=1, `ics` <= 0 (read clears). Reading while empty returns stale ICB and leaves `ics`=0.
  - addr 01: `d_out` <= {63'b0, `ics`}.
  - addr 10: `d_out` <= OCB (debug readback; no side effect).
  - addr 11: `d_out` <= {63'b0, `ocs`}.
- Processor write (`nicEn`=1, `nicEnWr`=1):
  - addr 10 with `ocs`=0: OCB <= `d_in`, `ocs` <= 1.
  - addr 10 with `ocs`=1: write dropped; OCB and `ocs` unchanged.
  - Writes to any other address are ignored.
- No access (`nicEn`=0): `d_out` holds its value.
- Output to router:
  - `net_so` = `ocs` && (OCB[63] == `net_polarity`). Bit 63 is the virtual-channel bit.
  - Transfer occurs on an edge where `net_so` && `net_ro`; effect: `ocs` <= 0. OCB data is retained.
  - `net_do` = OCB at all times.
- Simultaneous events:
  - Router write and processor ICB read in one cycle cannot coincide, because `net_ri`=0 whenever `ics`=1.
  - Processor OCB write and router drain cannot coincide, because they require opposite values of `ocs`.
  - A status read in the same cycle as a router write or drain returns the pre-edge flag.

## Timing
- Reset (`rst`=0 at an edge): ICB=0, OCB=0, `ics`=0, `ocs`=0, `d_out`=0.
  - Resulting outputs: `net_ri`=1, `net_so`=0, `net_do`=0.
  - Reset mid-transfer discards any buffered packet; reset overrides all other events in that cycle.
- Read latency: access at edge k updates `d_out` at edge k, so data is visible during cycle k+1. This matches the pipeline's stage-3 capture.
- ICB throughput:
  - Router write at edge k; processor read at edge k+1 clears `ics`.
  - `net_ri` is high after edge k+1, so the next router write can occur at edge k+2.
- OCB:
  - Processor write at edge k.
  - `net_so` rises in cycle k+1 if polarity matches.
  - Drain at the first edge with `net_so` && `net_ro`.
  - A wrong-polarity packet waits indefinitely for `net_polarity` to flip.
- `net_ri`, `net_so`, `net_do` depend on registered state plus `net_polarity` only; no combinational path from `net_si` or `net_ro`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles → `d_out`=0, `net_ri`=1, `net_so`=0, status reads at addr 01/11 return 0.
- Router inject: `net_si`=1, `net_di`=64'h0000_0000_DEAD_BEEF → `net_ri`=0 next cycle; read addr 01 → 1; read addr 00 → 64'h0000_0000_DEAD_BEEF; then status 0 and `net_ri`=1.
- Inject with full ICB: second packet 64'h1234 offered while `ics`=1 → not accepted; ICB still holds 64'hDEAD_BEEF until read; 64'h1234 accepted at edge k+2.
- Send, polarity gate: write 64'h8000_0000_0000_00AA to addr 10 with `net_polarity`=0, `net_ro`=1 → `net_so`=0. Set polarity=1 → `net_so`=1, `net_do`=64'h8000_0000_0000_00AA, `ocs` cleared next edge.
- Router backpressure: `ocs`=1, polarity match, `net_ro`=0 for 5 cycles → `net_so` held at 1. A write of 64'h55 to addr 10 is dropped, so OCB is unchanged. Set `net_ro`=1 → drain.
- Reset mid-operation: ICB and OCB full, assert `rst`=0 for one edge → both flags 0, `net_so`=0, `d_out`=0.
